count_ctrl: RTL and testbench
=============================

# count_ctrl

Run controller for the 8-bit demo counter. Replaces free-running derived clocks with a single-clock scheme: a shared prescaler produces a one-cycle count enable at one of four selectable rates. A start/stop/clear state machine sequences the 8-bit up/down count register, whose value drives the display path.

## Interface
- `N`, 30, prescaler width; every `DIVk` must fit in N bits.
- `DIV0`, 50_000_000, cycles per tick for rate 0 (slowest).
- `DIV1`, 5_000_000, cycles per tick for rate 1.
- `DIV2`, 500_000, cycles per tick for rate 2.
- `DIV3`, 50_000, cycles per tick for rate 3 (fastest).
- All `DIVk` ≥ 2.

Ports:
- `clk`, in, 1, single system clock; all logic is on the rising edge.
- `reset`, in, 1, synchronous, active-high.
- `start`, in, 1, level-sampled request to run or resume.
- `stop`, in, 1, level-sampled request to pause.
- `clear`, in, 1, returns to IDLE with count 0.
- `dir`, in, 1, direction: 1 = up, 0 = down. Sampled at each tick.
- `rate_sel`, in, 2, rate index 0..3.
- `count`, out, 8, counter value.
- `tick`, out, 1, one-cycle pulse, aligned with each new `count` value.
- `state`, out, 2, encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `busy`, out, 1, high when state is RUN.
- `done`, out, 1, high when state is DONE.

## Operation
- Reset values: `count`=0, `tick`=0, `state`=IDLE, `busy`=0, `done`=0, prescaler=0, `rate_q`=0.
- Command priority: `clear` > `stop` > `start`. Commands are evaluated each cycle.
- IDLE:
  - `start`: go to RUN; prescaler is set to 0; `rate_q` is loaded from `rate_sel`.
- RUN:
  - The prescaler increments each cycle.
  - At prescaler == `DIV[rate_q]`-1, the prescaler goes to 0, `count` steps by ±1 per `dir`, and `rate_q` reloads from `rate_sel`. Rate changes therefore take effect only at tick boundaries.
  - `stop`: go to PAUSE; the prescaler holds its value.
- PAUSE:
  - The prescaler and `count` are frozen.
  - `start`: return to RUN and resume from the held prescaler value.
  - `rate_sel` is reloaded into `rate_q` each cycle.
  - If the held prescaler is ≥ the new `DIV`-1, the next RUN cycle is a tick.
- `clear` in any state: go to IDLE with `count`=0 and prescaler=0.
- Arithmetic: `count` wraps modulo 256 (255+1→0, 0−1→255) unless the autostop feature is compiled in.
- Boundary rule: if `stop` and the terminal prescaler value occur in the same cycle, `stop` wins. No count update and no tick occur; the tick fires on the first RUN cycle after resume.

## Timing
- `start` asserted in IDLE at cycle t: `state`=RUN at t+1.
- First count update occurs at the edge ending cycle t+`DIV`. `count` and `tick` become visible in cycle t+`DIV`+1.
- Tick period in steady RUN is exactly `DIV[rate_q]` cycles.
- `tick` is registered: high for exactly one cycle per update, never in IDLE, PAUSE or DONE.
- `busy`/`done` are decoded from the registered state, so they change together with `state`.
- `clear` and `stop` take effect one cycle after sampling, with no partial update.

## Configuration
- `COUNT_CTRL_AUTOSTOP_EN` defined:
  - An update that reaches the terminal value (255 counting up, 0 counting down) moves the block to DONE in the same edge.
  - `tick` still pulses for that update.
  - DONE ignores `start` and `stop`; only `clear` or `reset` leaves it.
- Not defined:
  - `count` wraps around and DONE is unreachable.
  - `done` is tied to 0. `state` encoding is unchanged.

## Structure
- Package `count_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE/DONE, 2-bit);
  - rate index constants `RATE_0`..`RATE_3`;
  - direction constants `DIR_UP`/`DIR_DOWN`.
- Sub-module `tick_prescaler`:
  - inputs: N-bit counter, enable, sync clear, divisor select;
  - outputs: `terminal` flag and the held value.
- The FSM and count register stay in `count_ctrl`.

## Test plan
Bench parameters: DIV0=4, DIV1=3, DIV2=2, DIV3=5.
- Reset, then `start` with `rate_sel`=0, `dir`=1 → `state`=RUN next cycle; `tick` every 4 cycles; `count` goes 1, 2, 3.
- While running at rate 0, change `rate_sel` to 2 mid-period → the current period completes at 4 cycles; following periods are 2 cycles.
- Run 3 ticks, `stop` for 10 cycles, then `start` → `count` holds at 3 while paused and no tick occurs; after resume, the next tick arrives after the remaining prescaler cycles only.
- Assert `stop` on the terminal prescaler cycle → no tick that cycle; on resume, `tick` occurs on the first RUN cycle.
- `dir`=0 from `count`=0 → without the macro, `count`=255 and `state` stays RUN; with `COUNT_CTRL_AUTOSTOP_EN`, a count reaching 255→0 from 1 (or 254→255 counting up) sets `state`=DONE and `done`=1, and `start` is ignored.
- `clear` together with `start` and `stop` while in RUN → `state`=IDLE, `count`=0, no tick; `reset` in DONE → all outputs return to their reset values.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl run controller.
package count_ctrl_pkg;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RATE_0 = 2'd0;
  localparam logic [1:0] RATE_1 = 2'd1;
  localparam logic [1:0] RATE_2 = 2'd2;
  localparam logic [1:0] RATE_3 = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/count_ctrl_tick_prescaler.sv
// Shared prescaler: counts system clocks and flags the last cycle of a
// tick period for the selected rate. The held value survives while the
// enable is low, which is how a paused run resumes mid-period.
module tick_prescaler
  import count_ctrl_pkg::*;
#(
  parameter int unsigned N    = 30,
  parameter int unsigned DIV0 = 50_000_000,
  parameter int unsigned DIV1 = 5_000_000,
  parameter int unsigned DIV2 = 500_000,
  parameter int unsigned DIV3 = 50_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [1:0]   sel,
  output logic         terminal,
  output logic [N-1:0] value
);

  logic [N-1:0] last;

  // Last prescaler value of a period for the selected rate.
  always_comb begin
    last = N'(DIV0 - 1);
    case (sel)
      RATE_0:  last = N'(DIV0 - 1);
      RATE_1:  last = N'(DIV1 - 1);
      RATE_2:  last = N'(DIV2 - 1);
      RATE_3:  last = N'(DIV3 - 1);
      default: last = N'(DIV0 - 1);
    endcase
  end

  // A value held across a switch to a faster rate may already be past the
  // new end of period, so terminal uses >= rather than ==.
  assign terminal = (value >= last);

  // Prescaler register: clear wins over count.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= value + N'(1);
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Run controller for the 8-bit demo counter: start/stop/clear sequencer,
// shared rate prescaler and up/down count register on a single clock.
// Optional feature macro: COUNT_CTRL_AUTOSTOP_EN -- when defined, an update
// that lands on 255 (counting up) or 0 (counting down) parks the block in
// DONE until clear or reset; when undefined the count wraps and done is 0.
//
// state | meaning
// IDLE  | stopped, count 0, waiting for start
// RUN   | prescaler advancing, count steps on every tick
// PAUSE | prescaler and count frozen, rate_sel tracked
// DONE  | terminal count reached (autostop builds only)
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned N    = 30,
  parameter int unsigned DIV0 = 50_000_000,
  parameter int unsigned DIV1 = 5_000_000,
  parameter int unsigned DIV2 = 500_000,
  parameter int unsigned DIV3 = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       dir,
  input  logic [1:0] rate_sel,
  output logic [7:0] count,
  output logic       tick,
  output logic [1:0] state,
  output logic       busy,
  output logic       done
);

  state_t       cur_state, nxt_state;
  logic [1:0]   rate_q, rate_d;
  logic [7:0]   count_q, count_d;
  logic         tick_q, tick_d;
  logic         presc_en, presc_clr, terminal;
  // Held prescaler value is available for debug; the sequencer only needs terminal.
  logic [N-1:0] presc_value_unused;

  tick_prescaler #(
    .N   (N),
    .DIV0(DIV0),
    .DIV1(DIV1),
    .DIV2(DIV2),
    .DIV3(DIV3)
  ) u_presc (
    .clk     (clk),
    .reset   (reset),
    .en      (presc_en),
    .clr     (presc_clr),
    .sel     (rate_q),
    .terminal(terminal),
    .value   (presc_value_unused)
  );

  // Next-state, count update and prescaler control; clear overrides everything.
  always_comb begin
    nxt_state = cur_state;
    count_d   = count_q;
    rate_d    = rate_q;
    tick_d    = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (!stop && start) begin
          nxt_state = ST_RUN;
          presc_clr = 1'b1;
          rate_d    = rate_sel;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // stop beats a coincident terminal cycle: the tick is deferred.
          nxt_state = ST_PAUSE;
        end else if (terminal) begin
          presc_clr = 1'b1;
          tick_d    = 1'b1;
          rate_d    = rate_sel;
          count_d   = (dir == DIR_DOWN) ? count_q - 8'd1 : count_q + 8'd1;
`ifdef COUNT_CTRL_AUTOSTOP_EN
          if ((dir == DIR_UP && count_d == 8'hFF) ||
              (dir == DIR_DOWN && count_d == 8'h00)) begin
            nxt_state = ST_DONE;
          end
`endif
        end else begin
          presc_en = 1'b1;
        end
      end
      ST_PAUSE: begin
        rate_d = rate_sel;
        if (!stop && start) begin
          nxt_state = ST_RUN;
        end
      end
      ST_DONE: begin
        nxt_state = ST_DONE;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
    if (clear) begin
      nxt_state = ST_IDLE;
      count_d   = 8'd0;
      tick_d    = 1'b0;
      presc_en  = 1'b0;
      presc_clr = 1'b1;
    end
  end

  // State, count, rate and tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= ST_IDLE;
      count_q   <= 8'd0;
      rate_q    <= RATE_0;
      tick_q    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      count_q   <= count_d;
      rate_q    <= rate_d;
      tick_q    <= tick_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign state = cur_state;
  assign busy  = (cur_state == ST_RUN);
`ifdef COUNT_CTRL_AUTOSTOP_EN
  assign done  = (cur_state == ST_DONE);
`else
  assign done  = 1'b0;
`endif

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl with small divisors (4,3,2,5).
// A cycle-level reference model tracks elapsed cycles per period and the
// count in plain integer arithmetic; each scenario task compares outputs.
module tb_count_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear, dir;
  logic [1:0] rate_sel;
  logic [7:0] count;
  logic       tick;
  logic [1:0] state;
  logic       busy, done;

  int checks = 0;
  int passed = 0;

  // reference model: 0 idle, 1 run, 2 pause, 3 done
  int m_st, m_el, m_rate, m_cnt;
  bit m_tick;

  count_ctrl #(.N(N), .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(5)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .rate_sel(rate_sel), .count(count), .tick(tick),
    .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int mdiv(input int r);
    case (r)
      0: return 4;
      1: return 3;
      2: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] c;
    logic [1:0] s;
    c = m_cnt[7:0];
    s = m_st[1:0];
    return {c, m_tick, s, (m_st == 1), (m_st == 3)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {count, tick, state, busy, done};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input bit rs, input bit st, input bit sp, input bit cl,
                      input bit d, input bit [1:0] r);
    reset = rs; start = st; stop = sp; clear = cl; dir = d; rate_sel = r;
    @(posedge clk);
    m_tick = 1'b0;
    if (rs) begin
      m_st = 0; m_el = 0; m_rate = 0; m_cnt = 0;
    end else if (cl) begin
      m_st = 0; m_el = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: if (!sp && st) begin m_st = 1; m_el = 0; m_rate = r; end
        1: begin
          if (sp) m_st = 2;
          else if (m_el >= mdiv(m_rate) - 1) begin
            m_el = 0; m_tick = 1'b1; m_rate = r;
            m_cnt = d ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
`ifdef COUNT_CTRL_AUTOSTOP_EN
            if ((d && m_cnt == 255) || (!d && m_cnt == 0)) m_st = 3;
`endif
          end else m_el = m_el + 1;
        end
        2: begin m_rate = r; if (!sp && st) m_st = 1; end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 3);
    checks++;
    if (dut_vec() !== 13'h0) $display("FAIL reset_values: got %h expected %h", dut_vec(), 13'h0);
    else passed++;
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_basic();
    step(0, 1, 0, 0, 1, 0);
    checks++;
    if (state !== 2'd1 || busy !== 1'b1) $display("FAIL start_to_run: got state %0d busy %0b expected 1 1", state, busy);
    else passed++;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0, 0, 1, 0);
      checks++;
      if (tick !== (i % 4 == 0) || count !== 8'(i / 4))
        $display("FAIL basic_cycle%0d: got tick %0b count %0d expected %0b %0d", i, tick, count, (i % 4 == 0), i / 4);
      else passed++;
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL basic_model%0d: got %h expected %h", i, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_rate_change();
    int ticks[$];
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 2; i <= 12; i++) begin
      step(0, 0, 0, 0, 1, 2);
      if (tick) ticks.push_back(i);
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL rate_model%0d: got %h expected %h", i, dut_vec(), exp_vec());
      else passed++;
    end
    checks++;
    if (ticks.size() < 3 || ticks[0] != 4 || ticks[1] != 6 || ticks[2] != 8)
      $display("FAIL rate_change_periods: got %0d ticks first at %0d expected ticks at 4 6 8",
               ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
    else passed++;
  endtask

  task automatic test_pause();
    int n;
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    n = 0;
    while (count !== 8'd3 && n < 40) begin
      step(0, 0, 0, 0, 1, 0);
      n++;
    end
    checks++;
    if (count !== 8'd3) $display("FAIL pause_reach3: got count %0d expected 3", count);
    else passed++;
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    checks++;
    if (state !== 2'd2 || busy !== 1'b0) $display("FAIL pause_enter: got state %0d busy %0b expected 2 0", state, busy);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 0, 1, 0);
      checks++;
      if (count !== 8'd3 || tick !== 1'b0 || state !== 2'd2)
        $display("FAIL pause_hold%0d: got count %0d tick %0b state %0d expected 3 0 2", i, count, tick, state);
      else passed++;
    end
    step(0, 1, 0, 0, 1, 0);
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step(0, 0, 0, 0, 1, 0);
      n++;
    end
    checks++;
    if (n != 3 || count !== 8'd4) $display("FAIL pause_resume: got %0d cycles count %0d expected 3 cycles count 4", n, count);
    else passed++;
  endtask

  task automatic test_stop_terminal();
    int n;
    logic [7:0] saved;
    step(0, 0, 0, 1, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    n = 0;
    while (m_el != mdiv(m_rate) - 1 && n < 20) begin
      step(0, 0, 0, 0, 1, 1);
      n++;
    end
    checks++;
    if (n != 2) $display("FAIL stopterm_reach: got %0d cycles expected 2", n);
    else passed++;
    saved = count;
    step(0, 0, 1, 0, 1, 1);
    checks++;
    if (tick !== 1'b0 || state !== 2'd2 || count !== saved)
      $display("FAIL stopterm_no_tick: got tick %0b state %0d count %0d expected 0 2 %0d", tick, state, count, saved);
    else passed++;
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    checks++;
    if (tick !== 1'b1 || count !== saved + 8'd1)
      $display("FAIL stopterm_resume_tick: got tick %0b count %0d expected 1 %0d", tick, count, saved + 8'd1);
    else passed++;
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 1, 0, 2);
    step(0, 1, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 2);
    checks++;
    if (count !== 8'd255 || tick !== 1'b1 || state !== 2'd1)
      $display("FAIL wrap_down: got count %0d tick %0b state %0d expected 255 1 1", count, tick, state);
    else passed++;
    checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL wrap_model: got %h expected %h", dut_vec(), exp_vec());
    else passed++;
`ifdef COUNT_CTRL_AUTOSTOP_EN
    step(0, 0, 0, 1, 1, 2);
    step(0, 1, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 2);
    checks++;
    if (count !== 8'd0 || tick !== 1'b1 || state !== 2'd3 || done !== 1'b1)
      $display("FAIL autostop_done: got count %0d tick %0b state %0d done %0b expected 0 1 3 1", count, tick, state, done);
    else passed++;
    step(0, 1, 0, 0, 0, 2);
    step(0, 1, 0, 0, 0, 2);
    checks++;
    if (state !== 2'd3 || tick !== 1'b0) $display("FAIL autostop_ignore_start: got state %0d tick %0b expected 3 0", state, tick);
    else passed++;
`endif
  endtask

  task automatic test_clear_all();
    int n;
    step(0, 0, 0, 1, 1, 3);
    step(0, 1, 0, 0, 1, 3);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 3);
    n = 0;
    while (m_el != mdiv(m_rate) - 1 && n < 20) begin
      step(0, 0, 0, 0, 1, 3);
      n++;
    end
    step(0, 1, 1, 1, 1, 3);
    checks++;
    if (state !== 2'd0 || count !== 8'd0 || tick !== 1'b0 || busy !== 1'b0)
      $display("FAIL clear_priority: got state %0d count %0d tick %0b busy %0b expected 0 0 0 0", state, count, tick, busy);
    else passed++;
  endtask

  task automatic test_reset_active();
    step(0, 0, 0, 1, 1, 2);
    step(0, 1, 0, 0, 1, 2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 2);
`ifdef COUNT_CTRL_AUTOSTOP_EN
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 2);
`endif
    step(1, 0, 0, 0, 1, 2);
    checks++;
    if (dut_vec() !== 13'h0) $display("FAIL reset_active: got %h expected %h", dut_vec(), 13'h0);
    else passed++;
  endtask

  task automatic test_random();
    bit rs, st, sp, cl, d;
    bit [1:0] r;
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      cl = ($urandom_range(0, 49) == 0);
      sp = ($urandom_range(0, 99) < 8);
      st = ($urandom_range(0, 99) < 30);
      d  = ($urandom_range(0, 99) < 60);
      r  = 2'($urandom_range(0, 3));
      step(rs, st, sp, cl, d, r);
      checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random%0d: got %h expected %h", i, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b0; rate_sel = 2'd0;
    m_st = 0; m_el = 0; m_rate = 0; m_cnt = 0; m_tick = 1'b0;
    test_reset();
    test_basic();
    test_rate_change();
    test_pause();
    test_stop_terminal();
    test_wrap();
    test_clear_all();
    test_reset_active();
    step(0, 0, 0, 1, 0, 0);
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
